// File: rtl/example_bus_pkg.sv
// Shared types for the example bus initiator: command opcodes, FSM states
// and per-address reset-check lookup.
package example_bus_pkg;
  import example_sv_pkg::*;

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_WRITE  = 2'b01,
    OP_SWEEP  = 2'b10,
    OP_RSTCHK = 2'b11
  } cmdOpT;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP,
    ST_RESP
  } stateT;

  typedef struct packed {
    logic [data_width-1:0] value;
    logic                  check;
  } resetInfoT;

  function automatic resetInfoT resetInfo(input logic [addr_width-1:0] addr);
    resetInfoT info;
    info.value = example_reset_values[addr];
    info.check = ~example_unreset_mask[addr];
    return info;
  endfunction

endpackage

// File: rtl/example_sv_pkg.sv
// Register bank description for the example register block: widths, mirror
// struct, reset values, unreset flags and the mirror write helper.
package example_sv_pkg;

  localparam int addr_width       = 3;
  localparam int data_width       = 32;
  localparam int num_example_regs = 8;

  typedef struct packed {
    logic [25:0] reserved1;
    logic [1:0]  monkey2;
    logic [1:0]  reserved0;
    logic        error;
    logic        power;
  } example_reg2_type;

  // reg0 occupies the least significant word
  typedef struct packed {
    logic [data_width-1:0] reg7;
    logic [data_width-1:0] reg6;
    logic [data_width-1:0] reg5;
    logic [data_width-1:0] reg4;
    logic [data_width-1:0] reg3;
    example_reg2_type      reg2;
    logic [data_width-1:0] reg1;
    logic [data_width-1:0] reg0;
  } example_struct_type;

  typedef logic [num_example_regs-1:0][data_width-1:0] example_array_type;

  localparam example_array_type example_reset_values = {
    32'h0000_00FF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0010,
    32'h0000_00A5, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

  localparam logic [num_example_regs-1:0] example_unreset_mask = 8'h60;

  // Reserved fields of reg2 are read-only; writes leave them untouched
  localparam example_array_type example_write_mask = {
    {5{32'hFFFF_FFFF}}, 32'h0000_0033, {2{32'hFFFF_FFFF}}
  };

  function automatic example_struct_type write_example(
    input example_struct_type     cur,
    input logic [addr_width-1:0]  addr,
    input logic [data_width-1:0]  data
  );
    example_array_type regs;
    regs = example_array_type'(cur);
    regs[addr] = (data & example_write_mask[addr]) |
                 (regs[addr] & ~example_write_mask[addr]);
    return example_struct_type'(regs);
  endfunction

  function automatic example_struct_type load_example(
    input example_struct_type     cur,
    input logic [addr_width-1:0]  addr,
    input logic [data_width-1:0]  data
  );
    example_array_type regs;
    regs = example_array_type'(cur);
    regs[addr] = data;
    return example_struct_type'(regs);
  endfunction

endpackage

// File: rtl/example_bus_watchdog.sv
// Loadable down-counter that flags a stalled bus request once it reaches zero.
module example_bus_watchdog #(
  parameter int                   CNT_WIDTH  = 8,
  parameter logic [CNT_WIDTH-1:0] LOAD_VALUE = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_WIDTH-1:0] count;

  assign expired = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= LOAD_VALUE;
    end else if (clear) begin
      count <= LOAD_VALUE;
    end else if (enable && !expired) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/example_bus_initiator.sv
// Register-bus initiator: runs single and sweep transactions toward the example
// register responder and keeps a local mirror of the bank.
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_ISSUE | bus_req high, waiting for ack or watchdog expiry
// ST_GAP   | one idle bus cycle between sweep transactions
// ST_RESP  | rsp_valid pulse, then back to idle
module example_bus_initiator
  import example_sv_pkg::*;
  import example_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = addr_width,
  parameter int DATA_WIDTH     = data_width,
  parameter int NUM_REGS       = num_example_regs,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_mismatch,
  output example_struct_type    mirror,
  output logic [NUM_REGS-1:0]   mirror_valid
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  stateT                 state, nextState;
  cmdOpT                 opReg;
  logic [ADDR_WIDTH-1:0] addrReg;
  logic [DATA_WIDTH-1:0] wdataReg;
  logic [DATA_WIDTH-1:0] rspDataReg;
  logic                  weReg;
  logic                  errReg;
  logic [NUM_REGS-1:0]   maskReg;
  logic [NUM_REGS-1:0]   maskNext;
  logic                  accept;
  logic                  ackSeen;
  logic                  isSweep;
  logic                  moreAddr;
  logic                  inRange;
  logic                  checkHit;
  logic                  wdClear;
  logic                  wdEnable;
  logic                  wdExpired;
  resetInfoT             rstInfo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    cmd_ready = 1'b0;
    bus_req   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) nextState = ST_ISSUE;
      end
      ST_ISSUE: begin
        bus_req = 1'b1;
        if (bus_ack) begin
          nextState = moreAddr ? ST_GAP : ST_RESP;
        end else if (wdExpired) begin
          nextState = ST_RESP;
        end
      end
      ST_GAP: nextState = ST_ISSUE;
      ST_RESP: begin
        rsp_valid = 1'b1;
        nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    accept   = cmd_valid & cmd_ready;
    ackSeen  = bus_req & bus_ack;
    isSweep  = (opReg == OP_SWEEP) || (opReg == OP_RSTCHK);
    moreAddr = isSweep && (addrReg != LAST_ADDR);
    inRange  = 32'(addrReg) < 32'(NUM_REGS);
    rstInfo  = resetInfo(addrReg);
    checkHit = (opReg == OP_RSTCHK) && inRange && rstInfo.check &&
               (bus_rdata != rstInfo.value);
    maskNext = maskReg;
    if (ackSeen && checkHit) maskNext[addrReg] = 1'b1;
    // Watchdog reloads whenever the bus is idle, so each ISSUE entry starts fresh
    wdClear  = ~bus_req;
    wdEnable = bus_req & ~bus_ack;
  end

  example_bus_watchdog #(
    .CNT_WIDTH (8),
    .LOAD_VALUE(8'(TIMEOUT_CYCLES - 1))
  ) uWatchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wdClear),
    .enable (wdEnable),
    .expired(wdExpired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opReg        <= OP_READ;
      addrReg      <= '0;
      wdataReg     <= '0;
      weReg        <= 1'b0;
      errReg       <= 1'b0;
      maskReg      <= '0;
      rspDataReg   <= '0;
      mirror       <= '0;
      mirror_valid <= '0;
    end else begin
      if (accept) begin
        opReg      <= cmdOpT'(cmd_op);
        addrReg    <= (cmd_op[1]) ? '0 : cmd_addr;
        wdataReg   <= cmd_wdata;
        weReg      <= (cmdOpT'(cmd_op) == OP_WRITE);
        errReg     <= 1'b0;
        maskReg    <= '0;
        rspDataReg <= '0;
      end
      if (state == ST_GAP) begin
        addrReg <= addrReg + ADDR_WIDTH'(1);
      end
      if (ackSeen) begin
        maskReg <= maskNext;
        if (inRange) begin
          if (weReg) begin
            mirror <= write_example(mirror, addrReg, wdataReg);
          end else begin
            mirror                <= load_example(mirror, addrReg, bus_rdata);
            mirror_valid[addrReg] <= 1'b1;
          end
        end
        unique case (opReg)
          OP_READ:   rspDataReg <= bus_rdata;
          OP_RSTCHK: rspDataReg <= DATA_WIDTH'(maskNext);
          default:   rspDataReg <= '0;
        endcase
      end else if (bus_req && wdExpired) begin
        errReg     <= 1'b1;
        rspDataReg <= DATA_WIDTH'(addrReg);
      end
    end
  end

  assign bus_we       = weReg;
  assign bus_addr     = addrReg;
  assign bus_wdata    = wdataReg;
  assign rsp_rdata    = rspDataReg;
  assign rsp_error    = rsp_valid & errReg;
  assign rsp_mismatch = rsp_valid & (|maskReg);

endmodule

// File: doc/example_bus_initiator.md
Name: example_bus_initiator

Overview:
Bus initiator (master side) for the example register bank. It accepts commands from local control logic and drives a simple req/ack register bus toward the example register responder. Supported commands are single read, single write, full-map read sweep and reset-value check sweep. It maintains a local mirror of the register bank, typed as example_struct_type, and reports completion, timeout and reset-value mismatches.

Parameters:
ADDR_WIDTH, 3, register bus address width (equals package addr_width)
DATA_WIDTH, 32, register bus data width (equals package data_width)
NUM_REGS, 8, number of registers swept by sweep commands (addresses 0..NUM_REGS-1)
TIMEOUT_CYCLES, 16, max cycles bus_req may stay high without bus_ack; range 2..255

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  initiator idle, command accepted when cmd_valid&cmd_ready
cmd_op  in  2  00 read, 01 write, 10 sweep read, 11 reset check
cmd_addr  in  ADDR_WIDTH  target address for read/write
cmd_wdata  in  DATA_WIDTH  write data
bus_req  out  1  bus transaction request
bus_we  out  1  1=write, 0=read
bus_addr  out  ADDR_WIDTH  bus address
bus_wdata  out  DATA_WIDTH  bus write data
bus_ack  in  1  responder acknowledge, single-cycle
bus_rdata  in  DATA_WIDTH  read data, valid with bus_ack when bus_we=0
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data / mismatch mask / failing address
rsp_error  out  1  timeout occurred (valid with rsp_valid)
rsp_mismatch  out  1  reset check found mismatch (valid with rsp_valid)
mirror  out  $bits(example_struct_type)  mirrored register bank
mirror_valid  out  NUM_REGS  bit n set once register n mirrored

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except cmd_ready=1 after release; mirror=0, mirror_valid=0; FSM to IDLE. Mid-transaction reset drops bus_req immediately; no rsp_valid produced.
- FSM: IDLE -> ISSUE on accept; ISSUE: bus_req=1, addr/we/wdata stable until ack; ISSUE -> GAP on ack when more sweep addresses remain; ISSUE -> RESP on ack of last/only transaction or on timeout; GAP (1 cycle, bus_req=0) -> ISSUE with address+1; RESP: rsp_valid=1 for one cycle -> IDLE.
- cmd_ready=1 only in IDLE; bus_req asserts the cycle after accept. Single-op latency: accept to rsp_valid = ack-wait + 2 cycles (ack in first req cycle -> rsp_valid 2 cycles after accept).
- bus_ack sampled only while bus_req=1; ack with bus_req=0 ignored. bus_req drops the cycle after ack.
- Timeout: watchdog counts cycles with bus_req=1 and no ack. On reaching TIMEOUT_CYCLES, bus_req drops, sweep aborts, rsp_error=1, rsp_rdata = failing address zero-extended, mirror entry untouched. Counter clears on every new ISSUE entry.
- Read ack: mirror register at bus_addr <= bus_rdata; mirror_valid bit set. Write ack: mirror updated with bus_wdata via package write_example. Address >= NUM_REGS: transaction issued, mirror/mirror_valid untouched.
- rsp_rdata: read -> read data; write -> 0; sweep read -> 0; reset check -> mismatch mask in bits [NUM_REGS-1:0], upper bits 0.
- Reset check: each read compared with the package reset value; registers flagged unreset (reg5, reg6) never mismatch. rsp_mismatch = |mask. The mirror is also updated.
- rsp_mismatch and rsp_error are 0 outside rsp_valid.

Decomposition:
- example_sv_pkg (existing, generated) supplies register addresses, struct types, reset values, the unreset mask and write_example.
- New example_bus_pkg holds the cmd_op enum (OP_READ, OP_WRITE, OP_SWEEP, OP_RSTCHK), the FSM state enum and a function returning reset value and check-enable per address.
- One sub-module, example_bus_watchdog, holds the loadable timeout counter with clear, enable and expired outputs.

Test Plan:
- Reset, then op 00 addr 4. Responder acks in cycle 1 with 12 -> rsp_valid 2 cycles after accept, rsp_rdata=12, mirror.reg4=12, mirror_valid=8'h10.
- op 01 addr 2 wdata 0x35, then op 00 addr 2 (responder returns 0x35) -> mirror.reg2.monkey2=3, power=1, error=0.
- op 11 with responder at package reset values, reg5=0xDEAD and reg6=0xBEEF -> rsp_mismatch=0, rsp_rdata=0, mirror_valid=8'hFF. Repeat with reg4=13 -> rsp_mismatch=1, rsp_rdata=0x10.
- op 10 with responder ack delays 0..3 cycles random -> 8 reqs at addresses 0..7, each separated by exactly one low cycle, single rsp_valid.
- op 10 where responder never acks addr 3 -> bus_req drops after 16 cycles, rsp_error=1, rsp_rdata=3, mirror_valid=8'h07.
- Assert rst_n=0 during the addr 5 request of a sweep -> bus_req=0 the same cycle; mirror and mirror_valid=0; no rsp_valid; cmd_ready=1 after release.
